// File: rtl/muldiv_hilo_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit producing HI/LO write data and strobes.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiply, divides stay iterative.
module muldiv_hilo_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             hi_write,
  output logic             lo_write
);

  localparam int unsigned DW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, next_state;
  logic [CNT_W-1:0]   cnt;
  logic               op_div, sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [DW-1:0]      prod;

  logic               accept, fast_take, commit;
  logic               sgn_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag_in, b_mag_in;
  logic [WIDTH:0]     add_sum, shifted;
  logic [WIDTH-1:0]   sub_lo;
  logic [DW-1:0]      mul_step, div_step, mul_res;
  logic [WIDTH-1:0]   res_hi, res_lo, quo, rem, a_orig;

  assign accept   = (state == IDLE) && start && !flush;
  assign sgn_op   = ~op[0];
  assign a_neg    = sgn_op & src_a[WIDTH-1];
  assign b_neg    = sgn_op & src_b[WIDTH-1];
  assign a_mag_in = a_neg ? WIDTH'(-src_a) : src_a;
  assign b_mag_in = b_neg ? WIDTH'(-src_b) : src_b;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [WIDTH:0] fast_a, fast_b;
  logic [DW-1:0]         fast_prod;
  assign fast_a    = {a_neg, src_a};
  assign fast_b    = {b_neg, src_b};
  assign fast_prod = DW'(fast_a * fast_b);
  assign fast_take = accept && !op[1];
`else
  assign fast_take = 1'b0;
`endif

  // Shift-add multiply step: prod = {partial sum, remaining multiplier bits}
  assign add_sum  = {1'b0, prod[DW-1:WIDTH]} + (prod[0] ? {1'b0, mag_a} : '0);
  assign mul_step = {add_sum, prod[WIDTH-1:1]};

  // Restoring divide step: prod = {remainder, dividend/quotient bits}
  assign shifted  = prod[DW-1:WIDTH-1];
  assign sub_lo   = shifted[WIDTH-1:0] - mag_b;
  assign div_step = (shifted >= {1'b0, mag_b})
                  ? {sub_lo, prod[WIDTH-2:0], 1'b1}
                  : {shifted[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};

  // Sign fix-up of the magnitude result
  assign mul_res = (sign_a ^ sign_b) ? DW'(-prod) : prod;
  assign quo     = (sign_a ^ sign_b) ? WIDTH'(-prod[WIDTH-1:0]) : prod[WIDTH-1:0];
  assign rem     = sign_a ? WIDTH'(-prod[DW-1:WIDTH]) : prod[DW-1:WIDTH];
  assign a_orig  = sign_a ? WIDTH'(-mag_a) : mag_a;

  always_comb begin
    res_hi = mul_res[DW-1:WIDTH];
    res_lo = mul_res[WIDTH-1:0];
`ifdef MULDIV_FAST_MUL_EN
    if (fast_take) begin
      res_hi = fast_prod[DW-1:WIDTH];
      res_lo = fast_prod[WIDTH-1:0];
    end else
`endif
    if (op_div) begin
      if (mag_b == '0) begin
        res_hi = a_orig;
        res_lo = '1;
      end else begin
        res_hi = rem;
        res_lo = quo;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next state; DONE always commits even when flushed
  always_comb begin
    next_state = state;
    commit     = 1'b0;
    unique case (state)
      IDLE: begin
        commit = fast_take;
        if (accept && !fast_take) next_state = CALC;
      end
      CALC: begin
        if (flush)                          next_state = IDLE;
        else if (cnt == CNT_W'(ITER - 1))   next_state = DONE;
      end
      DONE: begin
        commit     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      op_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      prod   <= '0;
    end else if (accept) begin
      cnt    <= '0;
      op_div <= op[1];
      sign_a <= a_neg;
      sign_b <= b_neg;
      mag_a  <= a_mag_in;
      mag_b  <= b_mag_in;
      prod   <= {{WIDTH{1'b0}}, op[1] ? a_mag_in : b_mag_in};
    end else if (state == CALC) begin
      cnt  <= cnt + CNT_W'(1);
      prod <= op_div ? div_step : mul_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      hi_write <= 1'b0;
      lo_write <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
    end else begin
      busy     <= (next_state != IDLE);
      done     <= commit;
      hi_write <= commit;
      lo_write <= commit;
      if (commit) begin
        hi_out <= res_hi;
        lo_out <= res_lo;
      end
    end
  end

endmodule
